// File: rtl/cpu_mem_arbiter_if.sv
// Signal bundle between the arbiter, the fetch/mem-access requesters and the memory bus.
// master: arbiter side; slave: requesters plus bus slave.
`timescale 1ns/1ps
interface cpu_mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        stall;
    logic        bus_req;
    logic        bus_write;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wmask;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_error;

    modport master (
        input  if_req, if_addr, d_req, d_write, d_addr, d_wdata, d_wmask, bus_ack, bus_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, stall, bus_req, bus_write, bus_addr,
               bus_wdata, bus_wmask, bus_error
    );

    modport slave (
        output if_req, if_addr, d_req, d_write, d_addr, d_wdata, d_wmask, bus_ack, bus_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, stall, bus_req, bus_write, bus_addr,
               bus_wdata, bus_wmask, bus_error
    );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Shares the single memory bus between fetch and data requesters, one transaction at a time.
// Optional bus watchdog enabled by defining CPU_BUS_TIMEOUT_EN.
`timescale 1ns/1ps
module cpu_mem_arbiter #(
    parameter int unsigned TIMEOUT      = 255,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic               clock,
    input logic               reset,
    cpu_mem_arbiter_if.master arb
);
    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StResp} state_e;

    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

    state_e      r_state;
    logic [2:0]  r_starve_cnt;
    logic        r_bus_req;
    logic        r_bus_write;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_bus_wmask;
    logic        r_if_ack;
    logic        r_d_ack;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;

    logic        w_grant_d;
    logic        w_grant_i;
    logic        w_busy;
    logic        w_timeout;

    // Data wins unless a pending fetch has already been passed over STARVE_LIMIT times.
    assign w_grant_d = arb.d_req && !(arb.if_req && (r_starve_cnt == STARVE_MAX));
    assign w_grant_i = arb.if_req && !w_grant_d;
    assign w_busy    = (r_state == StBusyI) || (r_state == StBusyD);

`ifdef CPU_BUS_TIMEOUT_EN
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

    logic [15:0] r_wdog;
    logic        r_bus_error;

    // A bus_ack in the expiry cycle still completes normally.
    assign w_timeout     = w_busy && !arb.bus_ack && (r_wdog == WDOG_LAST);
    assign arb.bus_error = r_bus_error;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^TIMEOUT;
    assign w_timeout        = 1'b0;
    assign arb.bus_error    = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= StIdle;
            r_starve_cnt <= 3'd0;
            r_bus_req    <= 1'b0;
            r_bus_write  <= 1'b0;
            r_bus_addr   <= 32'd0;
            r_bus_wdata  <= 32'd0;
            r_bus_wmask  <= 4'd0;
            r_if_ack     <= 1'b0;
            r_d_ack      <= 1'b0;
            r_if_rdata   <= 32'd0;
            r_d_rdata    <= 32'd0;
`ifdef CPU_BUS_TIMEOUT_EN
            r_wdog       <= 16'd0;
            r_bus_error  <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_grant_d) begin
                        r_state     <= StBusyD;
                        r_bus_req   <= 1'b1;
                        r_bus_write <= arb.d_write;
                        r_bus_addr  <= arb.d_addr;
                        r_bus_wdata <= arb.d_wdata;
                        r_bus_wmask <= arb.d_wmask;
                    end else if (w_grant_i) begin
                        r_state     <= StBusyI;
                        r_bus_req   <= 1'b1;
                        r_bus_write <= 1'b0;
                        r_bus_addr  <= arb.if_addr;
                        r_bus_wdata <= 32'd0;
                        r_bus_wmask <= 4'd0;
                    end
                    if (!arb.if_req || w_grant_i) begin
                        r_starve_cnt <= 3'd0;
                    end else if (w_grant_d && (r_starve_cnt != STARVE_MAX)) begin
                        r_starve_cnt <= r_starve_cnt + 3'd1;
                    end
                end
                StBusyI, StBusyD: begin
                    if (arb.bus_ack || w_timeout) begin
                        r_bus_req <= 1'b0;
                        r_state   <= StResp;
                        if (r_state == StBusyI) begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= arb.bus_ack ? arb.bus_rdata : 32'd0;
                        end else begin
                            r_d_ack    <= 1'b1;
                            r_d_rdata  <= arb.bus_ack ? arb.bus_rdata : 32'd0;
                        end
                    end
                end
                StResp: begin
                    r_if_ack <= 1'b0;
                    r_d_ack  <= 1'b0;
                    r_state  <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
`ifdef CPU_BUS_TIMEOUT_EN
            if (r_state == StIdle) begin
                r_wdog <= 16'd0;
            end else if (w_busy) begin
                r_wdog <= r_wdog + 16'd1;
            end
            if (w_timeout) begin
                r_bus_error <= 1'b1;
            end
`endif
        end
    end

    assign arb.if_ack    = r_if_ack;
    assign arb.if_rdata  = r_if_rdata;
    assign arb.d_ack     = r_d_ack;
    assign arb.d_rdata   = r_d_rdata;
    assign arb.bus_req   = r_bus_req;
    assign arb.bus_write = r_bus_write;
    assign arb.bus_addr  = r_bus_addr;
    assign arb.bus_wdata = r_bus_wdata;
    assign arb.bus_wmask = r_bus_wmask;
    // Fetch waits are absorbed by the fetch stage; only data accesses stall the pipe.
    assign arb.stall     = arb.d_req & ~r_d_ack;
endmodule
